sprite_draw_controller: RTL
===========================

# sprite_draw_controller

Sequencing FSM that owns the VGA frame-buffer write port for one redraw. On a start request it waits for the next 4 Hz pacing tick, clears all 160x120 screen pixels to a background colour, then copies a 40x40 sprite from sprite ROM to a chosen screen position. It drives the screen and sprite address counters, the ROM read address and the frame-buffer write strobe, and sits between game logic and the frame-buffer RAM.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPRITE_W, 40, sprite width in pixels
- SPRITE_H, 40, sprite height in pixels
- TRANSPARENT_COLOUR, 3'b000, key colour; used only with SPRITE_TRANSPARENT_EN
- clk  in  1  system clock, all logic on rising edge
- spriteDrawControlReset  in  1  asynchronous, active-high reset
- start  in  1  redraw request, sampled only in IDLE
- tick  in  1  one-cycle 4 Hz pacing pulse from delay counter
- spriteX  in  8  sprite left column, latched at start
- spriteY  in  7  sprite top row, latched at start
- bgColour  in  3  background colour, latched at start
- spritePixel  in  3  sprite ROM data, valid 1 cycle after spriteAddr
- screenAddr  out  15  frame-buffer write address, y*SCREEN_W+x
- spriteAddr  out  11  sprite ROM read address, row*SPRITE_W+col
- writeEn  out  1  frame-buffer write strobe
- colourOut  out  3  frame-buffer write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when redraw completes

## Operation
- States: IDLE, WAIT_TICK, CLEAR, SPRITE, FLUSH.
- IDLE: start=1 latches spriteX/spriteY/bgColour, -> WAIT_TICK. start ignored in all other states.
- Latch clamps: spriteX > SCREEN_W-SPRITE_W stored as 120; spriteY > SCREEN_H-SPRITE_H stored as 80.
- WAIT_TICK: tick=1 -> CLEAR with screen counter 0. tick arriving in the same cycle as start is not used; next tick is required.
- CLEAR: each cycle writeEn=1, screenAddr=counter, colourOut=bgColour; counter increments; after address 19199 -> SPRITE.
- SPRITE: col/row counters scan 0..39 row-major; spriteAddr=row*40+col. Write stage is one cycle behind: writeEn=1, colourOut=spritePixel, screenAddr=(Y+row_d)*160+(X+col_d) using registered row_d/col_d. After col=39,row=39 issued -> FLUSH.
- FLUSH: final pipelined write performed; done=1 this cycle; -> IDLE.
- All address arithmetic is 15-bit unsigned; clamping guarantees max address 19199, no wrap.
- Reset (any time, including mid-CLEAR/SPRITE): immediately to IDLE, writeEn=0, no further writes; partial frame is left as is.

## Timing
- Reset values: screenAddr=0, spriteAddr=0, writeEn=0, colourOut=0, busy=0, done=0; all counters and latches 0.
- busy rises the cycle after start is sampled; falls the cycle after done.
- Start-to-first-write: 1 cycle after tick sampled high.
- CLEAR: exactly 19200 consecutive write cycles.
- SPRITE+FLUSH: 1601 cycles, 1600 write cycles (first SPRITE cycle only issues ROM address).
- No idle gap between last CLEAR write and first sprite write other than the single ROM-latency cycle.
- done is a single-cycle pulse; start in that same cycle is ignored (FSM still in FLUSH).

## Configuration
- SPRITE_TRANSPARENT_EN defined: in SPRITE/FLUSH write stage, writeEn=0 when spritePixel==TRANSPARENT_COLOUR; addresses still advance, cycle count unchanged.
- Undefined: every sprite pixel written regardless of value; TRANSPARENT_COLOUR unused.

## Test plan
- Reset, start with X=0,Y=0,bg=3'b101, tick 5 cycles later -> 19200 writes of 101 to 0..19199, then 1600 sprite writes, first to addr 0, last to addr 39*160+39=6279, done pulse once.
- Start with X=200,Y=100 -> clamped; first sprite write addr 80*160+120=12920, last 119*160+159=19199.
- Sprite ROM model returning spriteAddr[2:0] -> colourOut for write k equals k[2:0], verifying one-cycle alignment.
- Assert reset during CLEAR at addr 5000 -> writeEn low same cycle, busy=0, no writes until new start and tick.
- Pulse start during CLEAR and during done cycle -> ignored; exactly one done per accepted start.
- With SPRITE_TRANSPARENT_EN, ROM returning 000 for even addresses -> 800 sprite writes, only odd sprite addresses; without macro -> 1600 writes.

Source files
------------

// File: rtl/sprite_draw_controller.sv
// Redraw sequencer: waits for a pacing tick, clears the frame buffer, then copies a sprite.
// Define SPRITE_TRANSPARENT_EN to suppress writes of TRANSPARENT_COLOUR sprite pixels.
module sprite_draw_controller #(
  parameter int unsigned SCREEN_W           = 160,
  parameter int unsigned SCREEN_H           = 120,
  parameter int unsigned SPRITE_W           = 40,
  parameter int unsigned SPRITE_H           = 40,
  parameter logic [2:0]  TRANSPARENT_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        spriteDrawControlReset,
  input  logic        start,
  input  logic        tick,
  input  logic [7:0]  spriteX,
  input  logic [6:0]  spriteY,
  input  logic [2:0]  bgColour,
  input  logic [2:0]  spritePixel,
  output logic [14:0] screenAddr,
  output logic [10:0] spriteAddr,
  output logic        writeEn,
  output logic [2:0]  colourOut,
  output logic        busy,
  output logic        done
);

`ifdef SPRITE_TRANSPARENT_EN
  localparam bit TransparentEn = 1'b1;
`else
  localparam bit TransparentEn = 1'b0;
`endif

  localparam logic [7:0]  MaxX     = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0]  MaxY     = 7'(SCREEN_H - SPRITE_H);
  localparam logic [14:0] LastAddr = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [5:0]  LastCol  = 6'(SPRITE_W - 1);
  localparam logic [5:0]  LastRow  = 6'(SPRITE_H - 1);

  typedef enum logic [2:0] {StIdle, StWaitTick, StClear, StSprite, StFlush} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  bg_q;
  logic [14:0] cnt_q;
  logic [5:0]  col_q, row_q;
  logic [5:0]  col_dly_q, row_dly_q;
  logic        wr_vld_q;

  logic [14:0] wr_y, wr_x, sprite_wr_addr;
  logic        key_hit;

  always_ff @(posedge clk or posedge spriteDrawControlReset) begin
    if (spriteDrawControlReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = StWaitTick;
      StWaitTick: if (tick) state_d = StClear;
      StClear:    if (cnt_q == LastAddr) state_d = StSprite;
      StSprite:   if (col_q == LastCol && row_q == LastRow) state_d = StFlush;
      StFlush:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge spriteDrawControlReset) begin
    if (spriteDrawControlReset) begin
      x_q       <= '0;
      y_q       <= '0;
      bg_q      <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      col_dly_q <= '0;
      row_dly_q <= '0;
      wr_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            // Clamp so the sprite always lies fully on screen; no address can wrap.
            x_q  <= (spriteX > MaxX) ? MaxX : spriteX;
            y_q  <= (spriteY > MaxY) ? MaxY : spriteY;
            bg_q <= bgColour;
          end
        end
        StWaitTick: if (tick) cnt_q <= '0;
        StClear: begin
          cnt_q    <= cnt_q + 15'd1;
          col_q    <= '0;
          row_q    <= '0;
          wr_vld_q <= 1'b0;
        end
        StSprite: begin
          // Write stage trails the ROM address by one cycle to match ROM latency.
          col_dly_q <= col_q;
          row_dly_q <= row_q;
          wr_vld_q  <= 1'b1;
          if (col_q == LastCol) begin
            col_q <= '0;
            row_q <= (row_q == LastRow) ? '0 : row_q + 6'd1;
          end else begin
            col_q <= col_q + 6'd1;
          end
        end
        StFlush: wr_vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_y           = 15'(y_q) + 15'(row_dly_q);
    wr_x           = 15'(x_q) + 15'(col_dly_q);
    sprite_wr_addr = wr_y * 15'(SCREEN_W) + wr_x;
    key_hit        = TransparentEn && (spritePixel == TRANSPARENT_COLOUR);
    spriteAddr     = 11'(row_q) * 11'(SPRITE_W) + 11'(col_q);

    screenAddr = '0;
    writeEn    = 1'b0;
    colourOut  = '0;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    case (state_q)
      StClear: begin
        writeEn    = 1'b1;
        screenAddr = cnt_q;
        colourOut  = bg_q;
      end
      StSprite: begin
        writeEn    = wr_vld_q & ~key_hit;
        screenAddr = sprite_wr_addr;
        colourOut  = spritePixel;
      end
      StFlush: begin
        writeEn    = ~key_hit;
        screenAddr = sprite_wr_addr;
        colourOut  = spritePixel;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
